ddr_sample_sync: RTL and testbench



---
 rtl/ddr_sample_sync.sv | 97 +++++++++
 tb/tb_ddr_sample_sync.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_sample_sync.sv
// ddr_sample_sync
// Re-times the rising-edge (indata) and falling-edge (indata180) captured pad
// words into the clk domain and formats them into one sample word per clock.
//
// Ports:
//   clk          sample clock (same clock as the DDR capture buffer)
//   reset        asynchronous, active-high reset
//   indata       rising-edge captured pad data, WIDTH bits
//   indata180    falling-edge captured pad data, WIDTH bits
//   demux_mode   1 = pack the low halves of both edges into one word
//   filter_mode  1 = per-bit glitch filter (edges must agree to update)
//   test_mode    1 = internal counter pattern {~cnt, cnt}
//   sample_data  registered, formatted sample word
//   sample_valid sample_data is a fully pipelined word of the current format
//
// Format priority: test > demux > filter > passthrough.
// Pipeline: stage 1 captures pad words and mode bits, stage 2 formats them,
// so a pad word reaches sample_data two clock edges after it is presented.

module ddr_sample_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] indata,
  input  logic [WIDTH-1:0] indata180,
  input  logic             demux_mode,
  input  logic             filter_mode,
  input  logic             test_mode,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       mode_r;
  logic [2:0]       mode_in;
  logic [HALF-1:0]  cnt;
  logic [1:0]       fill;
  logic [1:0]       fill_next;
  logic             mode_chg;
  logic [WIDTH-1:0] data_next;

  assign mode_in  = {test_mode, demux_mode, filter_mode};
  assign mode_chg = (mode_r != mode_in);

  always_comb begin
    data_next = a_r;
    if (mode_r[2]) begin
      data_next = {~cnt, cnt};
    end else if (mode_r[1]) begin
      data_next = {b_r[HALF-1:0], a_r[HALF-1:0]};
    end else if (mode_r[0]) begin
      // A bit only moves when both edges agree; otherwise it keeps its
      // previous output value, so a half-cycle glitch is swallowed.
      data_next = (a_r & b_r) | (sample_data & (a_r ^ b_r));
    end
  end

  // Any change of the mode bits restarts the fill so the two words that may
  // mix old and new formats are flagged invalid.
  always_comb begin
    fill_next = fill;
    if (mode_chg) begin
      fill_next = 2'd0;
    end else if (fill != 2'd2) begin
      fill_next = fill + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r          <= '0;
      b_r          <= '0;
      mode_r       <= 3'b000;
      cnt          <= '0;
      fill         <= 2'd0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      a_r          <= indata;
      b_r          <= indata180;
      mode_r       <= mode_in;
      // Counter advances whenever the registered mode selects the pattern,
      // including on the edge where the mode bits are about to change.
      if (mode_r[2]) begin
        cnt <= cnt + 1'b1;
      end
      fill         <= fill_next;
      sample_data  <= data_next;
      sample_valid <= (fill_next == 2'd2);
    end
  end

endmodule

// File: tb/tb_ddr_sample_sync.sv
// Testbench for ddr_sample_sync: randomized pad data checked against a
// behavioural model (history of per-edge inputs and mode bits), plus
// directed scenarios with fixed expected words.

module tb_ddr_sample_sync;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic [W-1:0]  indata;
  logic [W-1:0]  indata180;
  logic          demux_mode;
  logic          filter_mode;
  logic          test_mode;
  logic [W-1:0]  sample_data;
  logic          sample_valid;

  int n_cmp;
  int n_err;

  // reference model state
  logic [W-1:0]  m_a;       // pad words presented at the previous edge
  logic [W-1:0]  m_b;
  logic [2:0]    m_mode;    // mode bits presented at the previous edge
  logic [2:0]    m_mode2;   // mode bits presented two edges ago
  logic [15:0]   m_cnt;     // number of pattern words produced (mod 2^16)
  int            m_edges;
  logic [W-1:0]  exp_data;
  logic          exp_valid;

  ddr_sample_sync #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .indata       (indata),
    .indata180    (indata180),
    .demux_mode   (demux_mode),
    .filter_mode  (filter_mode),
    .test_mode    (test_mode),
    .sample_data  (sample_data),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_a       = '0;
    m_b       = '0;
    m_mode    = 3'b000;
    m_mode2   = 3'b000;
    m_cnt     = '0;
    m_edges   = 0;
    exp_data  = '0;
    exp_valid = 1'b0;
  endfunction

  // One clock edge: the output is the format of what was presented one edge
  // earlier; a word is valid once two edges have passed since reset with the
  // mode bits unchanged across the last two edges.
  function automatic void model_step();
    logic [2:0] cur;
    cur = {test_mode, demux_mode, filter_mode};
    if (m_mode[2]) begin
      exp_data = {~m_cnt, m_cnt};
      m_cnt    = m_cnt + 16'd1;
    end else if (m_mode[1]) begin
      exp_data = {m_b[15:0], m_a[15:0]};
    end else if (m_mode[0]) begin
      exp_data = (m_a & m_b) | (exp_data & (m_a ^ m_b));
    end else begin
      exp_data = m_a;
    end
    if (m_edges < 2) m_edges = m_edges + 1;
    exp_valid = (m_edges >= 2) && (cur == m_mode) && (m_mode == m_mode2);
    m_mode2 = m_mode;
    m_mode  = cur;
    m_a     = indata;
    m_b     = indata180;
  endfunction

  // advance one posedge, update the model, return at the following negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_mode(input logic t, input logic d, input logic f);
    test_mode   = t;
    demux_mode  = d;
    filter_mode = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    indata    = $urandom;
    indata180 = $urandom;
    set_mode(1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (sample_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want %h", sample_data, 32'h0);
    end
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want %b", sample_valid, 1'b0);
    end
    do_reset();
  endtask

  task automatic test_passthrough();
    reset = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0);
    indata    = 32'hA5A5_0F0F;
    indata180 = 32'h0;
    do_reset();
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pass_first_valid: got %b want %b", sample_valid, 1'b0);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hA5A5_0F0F) begin
      n_err++;
      $display("FAIL pass_first_word: got %b/%h want 1/%h", sample_valid, sample_data, 32'hA5A5_0F0F);
    end
    for (int i = 0; i < 40; i++) begin
      indata    = $urandom;
      indata180 = $urandom;
      tick();
      n_cmp++;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_err++;
        $display("FAIL pass_rand[%0d]: got %b/%h want %b/%h", i, sample_valid, sample_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_demux();
    set_mode(1'b0, 1'b1, 1'b0);
    indata    = 32'hFFFF_1234;
    indata180 = 32'h0000_ABCD;
    tick();
    tick();
    n_cmp++;
    if (sample_data !== 32'hABCD_1234) begin
      n_err++;
      $display("FAIL demux_word: got %h want %h", sample_data, 32'hABCD_1234);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hABCD_1234) begin
      n_err++;
      $display("FAIL demux_valid: got %b/%h want 1/%h", sample_valid, sample_data, 32'hABCD_1234);
    end
    for (int i = 0; i < 40; i++) begin
      indata    = $urandom;
      indata180 = $urandom;
      tick();
      n_cmp++;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_err++;
        $display("FAIL demux_rand[%0d]: got %b/%h want %b/%h", i, sample_valid, sample_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_filter();
    set_mode(1'b0, 1'b0, 1'b1);
    indata    = 32'h0;
    indata180 = 32'h0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (sample_data !== 32'h0 || sample_valid !== 1'b1) begin
      n_err++;
      $display("FAIL filter_settle: got %b/%h want 1/%h", sample_valid, sample_data, 32'h0);
    end
    indata = 32'h1;
    tick();
    indata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (sample_data !== 32'h0) begin
        n_err++;
        $display("FAIL filter_glitch[%0d]: got %h want %h", i, sample_data, 32'h0);
      end
    end
    indata    = 32'h1;
    indata180 = 32'h1;
    tick();
    n_cmp++;
    if (sample_data !== 32'h0) begin
      n_err++;
      $display("FAIL filter_agree_early: got %h want %h", sample_data, 32'h0);
    end
    tick();
    n_cmp++;
    if (sample_data !== 32'h1) begin
      n_err++;
      $display("FAIL filter_agree: got %h want %h", sample_data, 32'h1);
    end
    for (int i = 0; i < 60; i++) begin
      // mostly-agreeing edges with a few random disagreeing bits
      indata    = $urandom;
      indata180 = indata ^ ($urandom & $urandom & $urandom);
      tick();
      n_cmp++;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_err++;
        $display("FAIL filter_rand[%0d]: got %b/%h want %b/%h", i, sample_valid, sample_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_mode_change();
    int low;
    set_mode(1'b0, 1'b0, 1'b0);
    indata    = 32'h1357_9BDF;
    indata180 = 32'h2468_ACE0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'h1357_9BDF) begin
      n_err++;
      $display("FAIL chg_before: got %b/%h want 1/%h", sample_valid, sample_data, 32'h1357_9BDF);
    end
    demux_mode = 1'b1;
    low = 0;
    for (int i = 0; i < 6 && sample_valid !== 1'b1 || i == 0; i++) begin
      tick();
      if (sample_valid !== 1'b1) low++;
    end
    n_cmp++;
    if (low != 2) begin
      n_err++;
      $display("FAIL chg_low_cycles: got %0d want %0d", low, 2);
    end
    n_cmp++;
    if (sample_data !== 32'hACE0_9BDF) begin
      n_err++;
      $display("FAIL chg_demux_word: got %h want %h", sample_data, 32'hACE0_9BDF);
    end
    for (int i = 0; i < 40; i++) begin
      indata    = $urandom;
      indata180 = $urandom;
      if ($urandom_range(0, 7) == 0) demux_mode = ~demux_mode;
      if ($urandom_range(0, 9) == 0) filter_mode = ~filter_mode;
      tick();
      n_cmp++;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_err++;
        $display("FAIL chg_rand[%0d]: got %b/%h want %b/%h", i, sample_valid, sample_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_pattern();
    int budget;
    reset = 1'b1;
    set_mode(1'b1, 1'b0, 1'b0);
    do_reset();
    tick();
    tick();
    n_cmp++;
    if (sample_data !== 32'hFFFF_0000) begin
      n_err++;
      $display("FAIL pattern_first: got %h want %h", sample_data, 32'hFFFF_0000);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hFFFE_0001) begin
      n_err++;
      $display("FAIL pattern_second: got %b/%h want 1/%h", sample_valid, sample_data, 32'hFFFE_0001);
    end
    budget = 70000;
    while (m_cnt != 16'hFFFF && budget > 0) begin
      indata    = $urandom;
      indata180 = $urandom;
      tick();
      budget--;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_cmp++;
        n_err++;
        $display("FAIL pattern_run: got %b/%h want %b/%h", sample_valid, sample_data, exp_valid, exp_data);
      end
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL pattern_budget: got %h want %h", m_cnt, 16'hFFFF);
    end
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'h0001_FFFE) begin
      n_err++;
      $display("FAIL pattern_pre_wrap: got %b/%h want 1/%h", sample_valid, sample_data, 32'h0001_FFFE);
    end
    // mode bits change on the same edge the counter wraps
    demux_mode = 1'b1;
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0 || sample_data !== 32'h0000_FFFF) begin
      n_err++;
      $display("FAIL wrap_edge: got %b/%h want 0/%h", sample_valid, sample_data, 32'h0000_FFFF);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0 || sample_data !== 32'hFFFF_0000) begin
      n_err++;
      $display("FAIL wrap_next: got %b/%h want 0/%h", sample_valid, sample_data, 32'hFFFF_0000);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hFFFE_0001) begin
      n_err++;
      $display("FAIL wrap_valid: got %b/%h want 1/%h", sample_valid, sample_data, 32'hFFFE_0001);
    end
    // pattern off: counter must hold through other modes
    set_mode(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    test_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (sample_data !== exp_data || sample_valid !== exp_valid) begin
        n_err++;
        $display("FAIL pattern_hold[%0d]: got %b/%h want %b/%h", i, sample_valid, sample_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    set_mode(1'b0, 1'b0, 1'b0);
    indata    = 32'hDEAD_BEEF;
    indata180 = 32'h0;
    budget = 10;
    tick();
    while (sample_valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL areset_pre: got %b/%h want 1/%h", sample_valid, sample_data, 32'hDEAD_BEEF);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (sample_data !== 32'h0 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_now: got %b/%h want 0/%h", sample_valid, sample_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_fill1: got %b want %b", sample_valid, 1'b0);
    end
    tick();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL areset_fill2: got %b/%h want 1/%h", sample_valid, sample_data, 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    indata    = '0;
    indata180 = '0;
    set_mode(1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_demux();
    test_filter();
    test_mode_change();
    test_pattern();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
